// File: rtl/key_encoder16_4.sv
// Registered, debounced 16-to-4 priority encoder with a one-deep press-event handshake.
// Raw key lines pass a two-flop synchroniser, a debounce FSM, then a highest-bit encoder.
module key_encoder16_4 #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] in_data,
  output logic [3:0]  out_code,
  output logic        out_valid,
  output logic        out_multi,
  output logic        ev_valid,
  output logic [3:0]  ev_code,
  input  logic        ev_ready,
  output logic        ev_overflow,
  output logic        release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  function automatic logic [3:0] f_encode(input logic [15:0] v);
    logic [3:0] enc;
    enc = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) enc = 4'(i);
    end
    return enc;
  endfunction

  logic [15:0]      r_sync1;
  logic [15:0]      r_in_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_cand;
  logic [15:0]      r_stable_mask;

  logic [3:0]       r_out_code;
  logic             r_out_valid;
  logic             r_out_multi;
  logic             r_ev_valid;
  logic [3:0]       r_ev_code;
  logic             r_ev_overflow;
  logic             r_release;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      w_cand_nxt;
  logic [15:0]      w_mask_nxt;
  logic             w_raise;
  logic             w_release;
  logic             w_sync_zero;
  logic [3:0]       w_cand_code;
  logic             w_cand_multi;

  assign w_sync_zero  = (r_in_sync == 16'h0000);
  assign w_cand_code  = f_encode(r_cand);
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_cand_multi = |(r_cand & (r_cand - 16'd1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_mask_nxt  = r_stable_mask;
    w_raise     = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_sync_zero) begin
          w_cand_nxt  = r_in_sync;
          w_cnt_nxt   = '0;
          w_state_nxt = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (w_sync_zero) begin
          w_state_nxt = IDLE;
        end else if (r_in_sync != r_cand) begin
          w_cand_nxt = r_in_sync;
          w_cnt_nxt  = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = PRESSED;
          w_mask_nxt  = r_cand;
          w_raise     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (r_in_sync == r_stable_mask) begin
          w_state_nxt = PRESSED;
        end else if (w_sync_zero) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DEB_REL;
        end else begin
          w_cand_nxt  = r_in_sync;
          w_cnt_nxt   = '0;
          w_state_nxt = DEB_PRESS;
        end
      end
      DEB_REL: begin
        if (r_in_sync == r_stable_mask) begin
          w_state_nxt = PRESSED;
        end else if (!w_sync_zero) begin
          w_cand_nxt  = r_in_sync;
          w_cnt_nxt   = '0;
          w_state_nxt = DEB_PRESS;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_sync1       <= '0;
      r_in_sync     <= '0;
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_cand        <= '0;
      r_stable_mask <= '0;
    end else begin
      r_sync1       <= in_data;
      r_in_sync     <= r_sync1;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cand        <= w_cand_nxt;
      r_stable_mask <= w_mask_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_out_code    <= '0;
      r_out_valid   <= 1'b0;
      r_out_multi   <= 1'b0;
      r_ev_valid    <= 1'b0;
      r_ev_code     <= '0;
      r_ev_overflow <= 1'b0;
      r_release     <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == PRESSED) || (w_state_nxt == DEB_REL);
      r_release   <= w_release;
      if (w_raise) begin
        r_out_code  <= w_cand_code;
        r_out_multi <= w_cand_multi;
      end else if ((w_state_nxt == IDLE) || (w_state_nxt == DEB_PRESS)) begin
        r_out_code  <= '0;
        r_out_multi <= 1'b0;
      end
      // A new event wins over an accept; it only overflows if the old one was not taken.
      if (w_raise) begin
        r_ev_valid <= 1'b1;
        r_ev_code  <= w_cand_code;
        if (r_ev_valid && !ev_ready) r_ev_overflow <= 1'b1;
      end else if (r_ev_valid && ev_ready) begin
        r_ev_valid <= 1'b0;
      end
    end
  end

  assign out_code      = r_out_code;
  assign out_valid     = r_out_valid;
  assign out_multi     = r_out_multi;
  assign ev_valid      = r_ev_valid;
  assign ev_code       = r_ev_code;
  assign ev_overflow   = r_ev_overflow;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_key_encoder16_4.sv
// Directed bench for key_encoder16_4: expected event codes go into a queue when a press
// is driven and are popped and compared when the event is consumed.
module tb_key_encoder16_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] in_data;
  logic        ev_ready;
  logic [3:0]  out_code;
  logic        out_valid;
  logic        out_multi;
  logic        ev_valid;
  logic [3:0]  ev_code;
  logic        ev_overflow;
  logic        release_pulse;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  key_encoder16_4 #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_data       (in_data),
    .out_code      (out_code),
    .out_valid     (out_valid),
    .out_multi     (out_multi),
    .ev_valid      (ev_valid),
    .ev_code       (ev_code),
    .ev_ready      (ev_ready),
    .ev_overflow   (ev_overflow),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {4'h0, out_valid, out_multi, out_code, ev_valid, ev_code, ev_overflow, release_pulse},
          16'h0000);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Drive a pattern and expect confirmation exactly 7 edges later (DEBOUNCE_CYCLES+3).
  task automatic do_press(input logic [15:0] pattern, input logic [3:0] code, input logic multi,
                          input logic accept_last, input string tag);
    in_data = pattern;
    repeat (6) tick();
    check({tag, "_valid_early"}, {15'h0, out_valid}, 16'h0000);
    check({tag, "_ev_early"}, {15'h0, ev_valid}, {15'h0, exp_q.size() > 0});
    if (accept_last) begin
      check({tag, "_old_ev"}, {15'h0, ev_valid}, 16'h0001);
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
      else check({tag, "_old_code"}, {12'h0, ev_code}, {12'h0, exp_q.pop_front()});
      ev_ready = 1'b1;
    end else if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovf = 1'b1;
    end
    exp_q.push_back(code);
    tick();
    ev_ready = 1'b0;
    check({tag, "_valid"}, {15'h0, out_valid}, 16'h0001);
    check({tag, "_code"}, {12'h0, out_code}, {12'h0, code});
    check({tag, "_multi"}, {15'h0, out_multi}, {15'h0, multi});
    check({tag, "_ev_valid"}, {15'h0, ev_valid}, 16'h0001);
    check({tag, "_ovf"}, {15'h0, ev_overflow}, {15'h0, exp_ovf});
  endtask

  task automatic accept_event(input string tag);
    check({tag, "_ev_valid"}, {15'h0, ev_valid}, 16'h0001);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    else check({tag, "_ev_code"}, {12'h0, ev_code}, {12'h0, exp_q.pop_front()});
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    check({tag, "_ev_drop"}, {15'h0, ev_valid}, 16'h0000);
  endtask

  task automatic do_release(input string tag);
    in_data = 16'h0000;
    repeat (6) tick();
    check({tag, "_held"}, {14'h0, out_valid, release_pulse}, 16'h0002);
    tick();
    check({tag, "_pulse"}, {10'h0, out_valid, release_pulse, out_code}, 16'h0010);
    tick();
    check({tag, "_pulse_end"}, {15'h0, release_pulse}, 16'h0000);
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    in_data  = 16'h0000;
    ev_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    do_press(16'h0020, 4'd5, 1'b0, 1'b0, "basic");
    accept_event("basic_acc");
    do_release("basic_rel");

    do_press(16'h8101, 4'd15, 1'b1, 1'b0, "prio");
    accept_event("prio_acc");
    do_release("prio_rel");

    for (int p = 0; p < 5; p++) begin
      for (int j = 0; j < 4; j++) begin
        in_data = (j < 2) ? 16'h0004 : 16'h0000;
        tick();
        check("bounce_quiet", {14'h0, out_valid, ev_valid}, 16'h0000);
      end
    end
    do_press(16'h0004, 4'd2, 1'b0, 1'b0, "bounce");
    accept_event("bounce_acc");

    in_data = 16'h0000;
    repeat (2) tick();
    in_data = 16'h0004;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("relbounce_hold", {13'h0, out_valid, release_pulse, ev_valid}, 16'h0004);
    end
    do_release("relbounce_rel");

    do_press(16'h0008, 4'd3, 1'b0, 1'b0, "ovf_a");
    do_release("ovf_rel");
    do_press(16'h0200, 4'd9, 1'b0, 1'b0, "ovf_b");
    check("ovf_code", {12'h0, ev_code}, {12'h0, exp_q[0]});

    in_data = 16'h0040;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst = 1'b0;
    model_reset();
    do_press(16'h0040, 4'd6, 1'b0, 1'b0, "rst_fresh");

    do_release("coin_rel");
    do_press(16'h0080, 4'd7, 1'b0, 1'b1, "coin");
    accept_event("coin_acc");
    do_release("coin_rel2");

    do_press(16'h0100, 4'd8, 1'b0, 1'b0, "en_a");
    enable = 1'b0;
    tick();
    check_all_zero("en_off");
    enable = 1'b1;
    model_reset();
    do_press(16'h0100, 4'd8, 1'b0, 1'b0, "en_b");
    accept_event("en_acc");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
